fault_aggregator: RTL and testbench

FAULT_AGGREGATOR -- requirements
Module: fault_aggregator

---
 rtl/fault_aggregator_if.sv | 34 +++
 rtl/fault_aggregator.sv | 141 ++++++++++++++
 tb/tb_fault_aggregator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fault_aggregator_if.sv
// Fault aggregator signal bundle: error inputs, clear/threshold controls,
// BIST pin handshake and the sticky fault outputs.
interface fault_aggregator_if #(
  parameter int NUM_CH     = 4,
  parameter int CERR_CNT_W = 8
);
  logic [NUM_CH-1:0]     uerr_in;
  logic [NUM_CH-1:0]     cerr_in;
  logic [NUM_CH-1:0]     chk_err_in;
  logic [CERR_CNT_W-1:0] cerr_thres;
  logic                  fault_clr;
  logic                  bist_pin;
  logic                  bist_next_ack;
  logic                  bist_next;
  logic                  bist_done;
  logic                  bist_fail;
  logic                  mission_fault;
  logic                  latent_fault;
  logic                  cerr_over_thres_fault;
  logic [NUM_CH-1:0]     fault_ch;
  logic [CERR_CNT_W-1:0] cerr_cnt;

  modport master (
    output uerr_in, cerr_in, chk_err_in, cerr_thres, fault_clr, bist_pin, bist_next_ack,
    input  bist_next, bist_done, bist_fail, mission_fault, latent_fault,
           cerr_over_thres_fault, fault_ch, cerr_cnt
  );

  modport slave (
    input  uerr_in, cerr_in, chk_err_in, cerr_thres, fault_clr, bist_pin, bist_next_ack,
    output bist_next, bist_done, bist_fail, mission_fault, latent_fault,
           cerr_over_thres_fault, fault_ch, cerr_cnt
  );
endinterface

// File: rtl/fault_aggregator.sv
// Collects per-channel error pulses into sticky fault flags and a saturating
// correctable-error count, and runs a pin-triggered 4-phase BIST of the checkers.
module fault_aggregator #(
  parameter int NUM_CH       = 4,
  parameter int CERR_CNT_W   = 8,
  parameter int BIST_STEPS   = 4,
  parameter int BIST_TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst,
  fault_aggregator_if.slave bus
);
  localparam int TMR_W = $clog2(BIST_TIMEOUT + 1);
  localparam int SUM_W = CERR_CNT_W + 5;

  typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

  state_t                state;
  logic [TMR_W-1:0]      timer;
  logic [3:0]            step;
  logic                  hit, pin_q;
  logic                  bist_next_q, done_q, fail_q;
  logic                  mission_q, latent_q, over_q;
  logic [NUM_CH-1:0]     fault_ch_q;
  logic [CERR_CNT_W-1:0] cnt_q, cnt_nxt;
  logic [SUM_W-1:0]      sum;
  logic [15:0]           chk_rep;
  logic [NUM_CH-1:0]     chk_vis;
  logic                  pin_rise, tmo, last, hit_nxt, bist_active;

  // Step k probes channel k mod NUM_CH; replicate so the step index selects directly.
  for (genvar i = 0; i < 16; i++) begin : g_rep
    assign chk_rep[i] = bus.chk_err_in[i % NUM_CH];
  end

  assign pin_rise    = bus.bist_pin & ~pin_q;
  assign tmo         = (timer == TMR_W'(BIST_TIMEOUT - 1));
  assign last        = (step == 4'(BIST_STEPS - 1));
  assign hit_nxt     = hit | chk_rep[step];
  assign bist_active = (state == REQ) || (state == REL);
  assign chk_vis     = bist_active ? '0 : bus.chk_err_in;

  always_comb begin
    sum = bus.fault_clr ? '0 : SUM_W'(cnt_q);
    for (int i = 0; i < NUM_CH; i++) sum = sum + SUM_W'(bus.cerr_in[i]);
    cnt_nxt = (sum > SUM_W'({CERR_CNT_W{1'b1}})) ? {CERR_CNT_W{1'b1}} : sum[CERR_CNT_W-1:0];
  end

  // Edge detector tracks the pin even in reset so a held-high pin cannot start a run.
  always_ff @(posedge clk) pin_q <= bus.bist_pin;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      step        <= '0;
      hit         <= 1'b0;
      bist_next_q <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pin_rise) begin
          state       <= REQ;
          bist_next_q <= 1'b1;
          done_q      <= 1'b0;
          fail_q      <= 1'b0;
          step        <= '0;
          hit         <= 1'b0;
          timer       <= '0;
        end
        REQ: begin
          hit <= hit_nxt;
          if (bus.bist_next_ack) begin
            state       <= REL;
            bist_next_q <= 1'b0;
            timer       <= '0;
          end else if (tmo) begin
            state       <= DONE;
            bist_next_q <= 1'b0;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REL: begin
          if (!bus.bist_next_ack) begin
            if (!hit_nxt) fail_q <= 1'b1;
            hit   <= 1'b0;
            timer <= '0;
            if (last) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state       <= REQ;
              step        <= step + 4'd1;
              bist_next_q <= 1'b1;
            end
          end else if (tmo) begin
            state  <= DONE;
            done_q <= 1'b1;
            fail_q <= 1'b1;
          end else begin
            hit   <= hit_nxt;
            timer <= timer + 1'b1;
          end
        end
        DONE: if (!bus.bist_pin) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // New errors in the clear cycle are OR-ed in after the clear, so they survive it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mission_q  <= 1'b0;
      latent_q   <= 1'b0;
      over_q     <= 1'b0;
      fault_ch_q <= '0;
      cnt_q      <= '0;
    end else begin
      mission_q  <= (bus.fault_clr ? 1'b0 : mission_q) | (|bus.uerr_in);
      fault_ch_q <= (bus.fault_clr ? '0 : fault_ch_q) | bus.uerr_in | chk_vis;
      latent_q   <= (bus.fault_clr ? 1'b0 : latent_q) | (|chk_vis) | ((state == DONE) && fail_q);
      over_q     <= (bus.fault_clr ? 1'b0 : over_q) |
                    (!bus.fault_clr && (bus.cerr_thres != '0) && (cnt_q >= bus.cerr_thres));
      cnt_q      <= cnt_nxt;
    end
  end

  assign bus.bist_next             = bist_next_q;
  assign bus.bist_done             = done_q;
  assign bus.bist_fail             = fail_q;
  assign bus.mission_fault         = mission_q;
  assign bus.latent_fault          = latent_q;
  assign bus.cerr_over_thres_fault = over_q;
  assign bus.fault_ch              = fault_ch_q;
  assign bus.cerr_cnt              = cnt_q;
endmodule

// File: tb/tb_fault_aggregator.sv
// Directed bench for fault_aggregator: sticky faults, counter saturation,
// BIST pass/fail/timeout and reset in the middle of a run.
module tb_fault_aggregator;
  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int STEPS  = 4;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  fault_aggregator_if #(.NUM_CH(NUM_CH), .CERR_CNT_W(W)) bus ();

  fault_aggregator #(.NUM_CH(NUM_CH), .CERR_CNT_W(W), .BIST_STEPS(STEPS), .BIST_TIMEOUT(TMO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_next(input logic lvl, output bit ok);
    int n = 0;
    while (bus.bist_next !== lvl && n < 40) begin tick(); n++; end
    ok = (bus.bist_next === lvl);
  endtask

  // Responder: pulse the step's checker once, ack after three cycles, release.
  task automatic do_step(input int k, input bit pulse, output bit ok);
    bit ok1, ok2;
    wait_next(1'b1, ok1);
    bus.chk_err_in = pulse ? NUM_CH'(1 << (k % NUM_CH)) : '0;
    tick();
    bus.chk_err_in = '0;
    tick(); tick();
    bus.bist_next_ack = 1'b1;
    wait_next(1'b0, ok2);
    bus.bist_next_ack = 1'b0;
    tick();
    ok = ok1 && ok2;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (bus.bist_done !== 1'b1 && n < 20) begin tick(); n++; end
    ok = (bus.bist_done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({bus.mission_fault, bus.latent_fault, bus.cerr_over_thres_fault,
         bus.bist_next, bus.bist_done, bus.bist_fail} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {bus.mission_fault,
        bus.latent_fault, bus.cerr_over_thres_fault, bus.bist_next, bus.bist_done, bus.bist_fail});
    end
    vectors++;
    if (bus.fault_ch !== 4'b0 || bus.cerr_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_vec: got ch=%b cnt=%0d want 0000/0", bus.fault_ch, bus.cerr_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_uerr();
    bus.uerr_in = 4'b0100; tick(); bus.uerr_in = '0;
    vectors++;
    if (bus.mission_fault !== 1'b1 || bus.fault_ch !== 4'b0100) begin
      errors++; $display("FAIL uerr_set: got mf=%b ch=%b want 1/0100", bus.mission_fault, bus.fault_ch);
    end
    tick();
    vectors++;
    if (bus.mission_fault !== 1'b1) begin
      errors++; $display("FAIL uerr_sticky: got %b want 1", bus.mission_fault);
    end
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    vectors++;
    if (bus.mission_fault !== 1'b0 || bus.fault_ch !== 4'b0000) begin
      errors++; $display("FAIL uerr_clr: got mf=%b ch=%b want 0/0000", bus.mission_fault, bus.fault_ch);
    end
  endtask

  task automatic test_cerr();
    bus.cerr_thres = 8'd3;
    bus.cerr_in = 4'b0011; tick();
    vectors++;
    if (bus.cerr_cnt !== 8'd2) begin
      errors++; $display("FAIL cerr_cnt1: got %0d want 2", bus.cerr_cnt);
    end
    tick();
    vectors++;
    if (bus.cerr_cnt !== 8'd4 || bus.cerr_over_thres_fault !== 1'b0) begin
      errors++; $display("FAIL cerr_cnt2: got cnt=%0d over=%b want 4/0", bus.cerr_cnt, bus.cerr_over_thres_fault);
    end
    bus.cerr_in = '0; tick();
    vectors++;
    if (bus.cerr_over_thres_fault !== 1'b1) begin
      errors++; $display("FAIL cerr_over: got %b want 1", bus.cerr_over_thres_fault);
    end
    // clear coincident with fresh errors: the fresh ones survive
    bus.fault_clr = 1'b1; bus.cerr_in = 4'b0001; bus.uerr_in = 4'b0001; tick();
    bus.fault_clr = 1'b0; bus.cerr_in = '0; bus.uerr_in = '0;
    vectors++;
    if (bus.cerr_cnt !== 8'd1 || bus.mission_fault !== 1'b1 || bus.fault_ch !== 4'b0001 ||
        bus.cerr_over_thres_fault !== 1'b0) begin
      errors++; $display("FAIL clr_vs_err: got cnt=%0d mf=%b ch=%b over=%b want 1/1/0001/0",
        bus.cerr_cnt, bus.mission_fault, bus.fault_ch, bus.cerr_over_thres_fault);
    end
    bus.cerr_in = 4'b1111;
    for (int i = 0; i < 200; i++) tick();
    bus.cerr_in = '0; tick();
    vectors++;
    if (bus.cerr_cnt !== 8'd255) begin
      errors++; $display("FAIL cerr_sat: got %0d want 255", bus.cerr_cnt);
    end
    bus.cerr_thres = 8'd0;
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    bus.cerr_in = 4'b1111; tick(); bus.cerr_in = '0;
    tick(); tick();
    vectors++;
    if (bus.cerr_cnt !== 8'd4 || bus.cerr_over_thres_fault !== 1'b0) begin
      errors++; $display("FAIL thres_off: got cnt=%0d over=%b want 4/0", bus.cerr_cnt, bus.cerr_over_thres_fault);
    end
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    vectors++;
    if (bus.cerr_cnt !== 8'd0 || bus.mission_fault !== 1'b0) begin
      errors++; $display("FAIL cerr_clr: got cnt=%0d mf=%b want 0/0", bus.cerr_cnt, bus.mission_fault);
    end
  endtask

  task automatic test_chk_idle();
    bus.chk_err_in = 4'b0010; tick(); bus.chk_err_in = '0;
    vectors++;
    if (bus.latent_fault !== 1'b1 || bus.fault_ch !== 4'b0010) begin
      errors++; $display("FAIL chk_idle: got lf=%b ch=%b want 1/0010", bus.latent_fault, bus.fault_ch);
    end
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    vectors++;
    if (bus.latent_fault !== 1'b0 || bus.fault_ch !== 4'b0) begin
      errors++; $display("FAIL chk_clr: got lf=%b ch=%b want 0/0000", bus.latent_fault, bus.fault_ch);
    end
  endtask

  task automatic test_bist(input bit skip2);
    bit ok;
    int hs = 0;
    bus.bist_pin = 1'b1; tick();
    for (int k = 0; k < STEPS; k++) begin
      do_step(k, !(skip2 && k == 2), ok);
      if (ok) hs++;
    end
    wait_done(ok);
    vectors++;
    if (hs != STEPS || !ok) begin
      errors++; $display("FAIL bist_hs: got %0d handshakes done=%b want %0d/1", hs, bus.bist_done, STEPS);
    end
    vectors++;
    if (bus.bist_fail !== skip2) begin
      errors++; $display("FAIL bist_fail: got %b want %b", bus.bist_fail, skip2);
    end
    tick();
    vectors++;
    if (bus.latent_fault !== skip2 || bus.fault_ch !== 4'b0) begin
      errors++; $display("FAIL bist_latent: got lf=%b ch=%b want %b/0000", bus.latent_fault, bus.fault_ch, skip2);
    end
    bus.bist_pin = 1'b0; tick();
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
    vectors++;
    if (bus.bist_done !== 1'b1 || bus.bist_fail !== skip2 || bus.latent_fault !== 1'b0) begin
      errors++; $display("FAIL bist_hold: got done=%b fail=%b lf=%b want 1/%b/0",
        bus.bist_done, bus.bist_fail, bus.latent_fault, skip2);
    end
  endtask

  task automatic test_timeout();
    bus.bist_pin = 1'b1; tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    vectors++;
    if (bus.bist_done !== 1'b0 || bus.bist_next !== 1'b1) begin
      errors++; $display("FAIL tmo_early: got done=%b next=%b want 0/1", bus.bist_done, bus.bist_next);
    end
    tick();
    vectors++;
    if (bus.bist_done !== 1'b1 || bus.bist_fail !== 1'b1 || bus.bist_next !== 1'b0) begin
      errors++; $display("FAIL tmo_hit: got done=%b fail=%b next=%b want 1/1/0",
        bus.bist_done, bus.bist_fail, bus.bist_next);
    end
    bus.bist_pin = 1'b0; tick();
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.bist_pin = 1'b1; tick();
    bus.uerr_in = 4'b1000; bus.cerr_in = 4'b1000; tick();
    bus.uerr_in = '0; bus.cerr_in = '0;
    do_step(0, 1'b1, ok);
    wait_next(1'b1, ok);
    bus.bist_next_ack = 1'b1;
    wait_next(1'b0, ok);
    vectors++;
    if (!ok || bus.mission_fault !== 1'b1 || bus.cerr_cnt !== 8'd1) begin
      errors++; $display("FAIL mid_setup: got rel=%b mf=%b cnt=%0d want 1/1/1", ok, bus.mission_fault, bus.cerr_cnt);
    end
    rst = 1'b1; tick();
    rst = 1'b0; bus.bist_next_ack = 1'b0;
    vectors++;
    if ({bus.mission_fault, bus.latent_fault, bus.cerr_over_thres_fault, bus.bist_next,
         bus.bist_done, bus.bist_fail} !== 6'b0 || bus.fault_ch !== 4'b0 || bus.cerr_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_reset: got flags=%b ch=%b cnt=%0d want 000000/0000/0",
        {bus.mission_fault, bus.latent_fault, bus.cerr_over_thres_fault, bus.bist_next,
         bus.bist_done, bus.bist_fail}, bus.fault_ch, bus.cerr_cnt);
    end
    tick(); tick(); tick();
    vectors++;
    if (bus.bist_next !== 1'b0) begin
      errors++; $display("FAIL no_restart: got next=%b want 0", bus.bist_next);
    end
    bus.bist_pin = 1'b0; tick();
    bus.bist_pin = 1'b1; tick();
    vectors++;
    if (bus.bist_next !== 1'b1 || bus.bist_done !== 1'b0) begin
      errors++; $display("FAIL restart: got next=%b done=%b want 1/0", bus.bist_next, bus.bist_done);
    end
    bus.bist_pin = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.uerr_in = '0; bus.cerr_in = '0; bus.chk_err_in = '0;
    bus.cerr_thres = '0; bus.fault_clr = 1'b0;
    bus.bist_pin = 1'b0; bus.bist_next_ack = 1'b0;
    test_reset();
    test_uerr();
    test_cerr();
    test_chk_idle();
    test_bist(1'b0);
    test_bist(1'b1);
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
